// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 configuration sequencer.
package ov7670_cfg_pkg;

   localparam int ROM_AW = 8;

   // Special ROM words: end of table, and a timed pause.
   localparam logic [15:0] CFG_END   = 16'hFFFF;
   localparam logic [15:0] CFG_DELAY = 16'hFFF0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      ISSUE,
      WAIT,
      DELAY,
      DONE
   } cfg_state_t;

   // The last ROM entry ends the sequence instead of wrapping to 0.
   function automatic logic is_last_addr(input logic [ROM_AW-1:0] addr);
      return addr == {ROM_AW{1'b1}};
   endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter with a zero flag. Used for FFF0 pauses and, when
// enabled, the SCCB watchdog. Holds at 0 once it gets there.
module cfg_delay_timer #(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_reg;

   assign zero = (count_reg == '0);

   // Load takes priority; otherwise count down while enabled, stopping at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && !zero) begin
         count_reg <= count_reg - 1'b1;
      end
   end

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// Walks the OV7670 configuration ROM and issues one SCCB write per entry.
// FFF0 entries pause for DELAY_CYCLES clocks, FFFF ends the table.
// Optional SCCB watchdog: define CFG_SCCB_TIMEOUT_EN.
module ov7670_cfg_sequencer
   import ov7670_cfg_pkg::*;
#(
   parameter int DELAY_CYCLES   = 250000,
   parameter int DELAY_W        = 18,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              sccb_req,
   input  logic              sccb_ready,
   output logic [7:0]        sccb_reg,
   output logic [7:0]        sccb_val,
   input  logic              sccb_done,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [DELAY_W-1:0] DELAY_LOAD = DELAY_W'(DELAY_CYCLES - 1);

   cfg_state_t        state_reg;
   logic [ROM_AW-1:0] rom_addr_reg;
   logic              sccb_req_reg;
   logic [7:0]        reg_addr_reg;
   logic [7:0]        reg_val_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              error_reg;

   logic is_write;
   logic delay_load;
   logic delay_dec;
   logic delay_zero;
   logic timeout;

   assign is_write   = (rom_data != CFG_END) && (rom_data != CFG_DELAY);
   assign delay_load = (state_reg == DECODE) && (rom_data == CFG_DELAY);
   assign delay_dec  = (state_reg == DELAY);

   cfg_delay_timer #(
      .W (DELAY_W)
   ) u_delay (
      .clk      (clk),
      .rst      (rst),
      .load     (delay_load),
      .load_val (DELAY_LOAD),
      .dec      (delay_dec),
      .zero     (delay_zero)
   );

`ifdef CFG_SCCB_TIMEOUT_EN
   localparam logic [15:0] WD_LOAD = 16'(TIMEOUT_CYCLES - 1);

   logic wd_load;
   logic wd_dec;
   logic wd_zero;

   // Watchdog restarts on every ISSUE entry and runs through ISSUE and WAIT.
   assign wd_load = (state_reg == DECODE) && is_write;
   assign wd_dec  = (state_reg inside {ISSUE, WAIT});
   assign timeout = wd_dec && wd_zero;

   cfg_delay_timer #(
      .W (16)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .load     (wd_load),
      .load_val (WD_LOAD),
      .dec      (wd_dec),
      .zero     (wd_zero)
   );
`else
   // No watchdog: ISSUE/WAIT wait forever and error_reg never sets.
   assign timeout = 1'b0;

   // TIMEOUT_CYCLES keeps its meaning for builds that enable the watchdog.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_out_of_range
   end
`endif

   // Sequencer FSM; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         rom_addr_reg <= '0;
         sccb_req_reg <= 1'b0;
         reg_addr_reg <= '0;
         reg_val_reg  <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  rom_addr_reg <= '0;
                  busy_reg     <= 1'b1;
                  done_reg     <= 1'b0;
                  error_reg    <= 1'b0;
                  state_reg    <= FETCH;
               end else begin
                  state_reg <= IDLE;
               end
            end
            FETCH: begin
               state_reg <= DECODE;
            end
            DECODE: begin
               if (rom_data == CFG_END) begin
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else if (rom_data == CFG_DELAY) begin
                  state_reg <= DELAY;
               end else begin
                  reg_addr_reg <= rom_data[15:8];
                  reg_val_reg  <= rom_data[7:0];
                  sccb_req_reg <= 1'b1;
                  state_reg    <= ISSUE;
               end
            end
            ISSUE: begin
               if (timeout) begin
                  sccb_req_reg <= 1'b0;
                  error_reg    <= 1'b1;
                  busy_reg     <= 1'b0;
                  done_reg     <= 1'b0;
                  state_reg    <= IDLE;
               end else if (sccb_ready) begin
                  sccb_req_reg <= 1'b0;
                  state_reg    <= WAIT;
               end
            end
            WAIT: begin
               if (timeout) begin
                  error_reg <= 1'b1;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else if (sccb_done) begin
                  if (is_last_addr(rom_addr_reg)) begin
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     rom_addr_reg <= rom_addr_reg + 1'b1;
                     state_reg    <= FETCH;
                  end
               end
            end
            DELAY: begin
               if (delay_zero) begin
                  if (is_last_addr(rom_addr_reg)) begin
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     rom_addr_reg <= rom_addr_reg + 1'b1;
                     state_reg    <= FETCH;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign rom_addr = rom_addr_reg;
   // The request drops as soon as rst rises, since the master resets with it.
   assign sccb_req = sccb_req_reg && !rst;
   assign sccb_reg = reg_addr_reg;
   assign sccb_val = reg_val_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign error    = error_reg;

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Self-checking bench for ov7670_cfg_sequencer: ROM and SCCB responder models,
// directed scenarios plus randomized tables compared against a table walk.
module tb_ov7670_cfg_sequencer;

   localparam int DC = 8;
   localparam int TC = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        sccb_req;
   logic        sccb_ready = 1'b0;
   logic [7:0]  sccb_reg;
   logic [7:0]  sccb_val;
   logic        sccb_done = 1'b0;
   logic        busy;
   logic        done;
   logic        error;

   int errors = 0;
   int checks = 0;

   ov7670_cfg_sequencer #(
      .DELAY_CYCLES   (DC),
      .DELAY_W        (4),
      .TIMEOUT_CYCLES (TC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .sccb_req   (sccb_req),
      .sccb_ready (sccb_ready),
      .sccb_reg   (sccb_reg),
      .sccb_val   (sccb_val),
      .sccb_done  (sccb_done),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   // Synchronous ROM with one-cycle read latency.
   logic [15:0] rom_mem [256];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SCCB responder: records each accepted write, pulses done lat cycles later
   // (lat == 0 means never).
   int          lat = 5;
   int          pend = 0;
   logic [15:0] got_q [$];
   always @(posedge clk) begin
      sccb_done <= 1'b0;
      if (rst) begin
         pend = 0;
      end else begin
         if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) sccb_done <= 1'b1;
         end
         if (sccb_req && sccb_ready) begin
            got_q.push_back({sccb_reg, sccb_val});
            pend = lat;
         end
      end
   end

   // Ready driver: forced low, random, or always high.
   bit hold_low   = 1'b0;
   bit rand_ready = 1'b0;
   always @(negedge clk) begin
      sccb_ready = hold_low ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
   end

   // Output monitor: request rises, done pulses, done rise, field stability.
   logic        req_prev  = 1'b0;
   logic        done_prev = 1'b0;
   logic [15:0] fld_prev  = '0;
   int          stab_err  = 0;
   int          done_rise = -1;
   int          rise_q [$];
   int          done_q [$];
   always @(negedge clk) begin
      if (sccb_req && req_prev && ({sccb_reg, sccb_val} !== fld_prev)) stab_err++;
      if (sccb_req && !req_prev) rise_q.push_back(cyc);
      if (sccb_done) done_q.push_back(cyc);
      if (done && !done_prev) done_rise = cyc;
      req_prev  = sccb_req;
      done_prev = done;
      fld_prev  = {sccb_reg, sccb_val};
   end

   // Reference: the writes the table should produce, in order.
   logic [15:0] exp_q [$];
   function automatic void build_expected();
      exp_q.delete();
      for (int a = 0; a < 256; a++) begin
         if (rom_mem[a] == 16'hFFFF) break;
         if (rom_mem[a] != 16'hFFF0) exp_q.push_back(rom_mem[a]);
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         step();
         n++;
      end
      check("done_reached", 32'(done), 32'd1);
   endtask

   task automatic wait_req(input int budget);
      int n = 0;
      while (!sccb_req && n < budget) begin
         step();
         n++;
      end
      check("req_reached", 32'(sccb_req), 32'd1);
   endtask

   task automatic compare_writes(input string tag, input int base);
      build_expected();
      check({tag, "_count"}, 32'(got_q.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < got_q.size())
            check($sformatf("%s_w%0d", tag, i), 32'(got_q[base + i]), 32'(exp_q[i]));
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
   endtask

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      w = 16'($urandom);
      if (w == 16'hFFFF || w == 16'hFFF0) w = 16'h1234;
      return w;
   endfunction

   task automatic load_basic();
      clear_rom();
      rom_mem[0] = 16'h1280;
      rom_mem[1] = 16'hFFF0;
      rom_mem[2] = 16'h1204;
   endtask

   initial begin
      int gb, rb, db, gap, n, a;

      rst   = 1'b1;
      start = 1'b0;
      clear_rom();
      repeat (3) step();
      check("rst_req", 32'(sccb_req), 32'd0);
      rst = 1'b0;
      step();
      check("reset_rom_addr", 32'(rom_addr), 32'd0);
      check("reset_req", 32'(sccb_req), 32'd0);
      check("reset_fields", 32'({sccb_reg, sccb_val}), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_error", 32'(error), 32'd0);
      $display("txn reset: outputs idle");

      // Basic table with a pause between the two writes.
      load_basic();
      gb = got_q.size(); rb = rise_q.size(); db = done_q.size();
      pulse_start();
      check("t1_busy_after_start", 32'(busy), 32'd1);
      check("t1_req_fetch", 32'(sccb_req), 32'd0);
      step();
      check("t1_req_decode", 32'(sccb_req), 32'd0);
      step();
      check("t1_req_issue", 32'(sccb_req), 32'd1);
      wait_done(500);
      compare_writes("t1", gb);
      gap = (rise_q.size() >= rb + 2 && done_q.size() >= db + 1) ? rise_q[rb + 1] - done_q[db] : -1;
      check("t1_delay_gap", 32'(gap), 32'(3 + DC + 2));
      gap = (done_q.size() >= db + 2) ? done_rise - done_q[db + 1] : -1;
      check("t1_done_latency", 32'(gap), 32'd3);
      check("t1_busy_end", 32'(busy), 32'd0);
      repeat (5) step();
      check("t1_done_sticky", 32'(done), 32'd1);
      $display("txn basic: %0d writes", got_q.size() - gb);

      // Ready withheld for 20 cycles while a request is pending.
      clear_rom();
      rom_mem[0] = 16'h12AB;
      hold_low = 1'b1;
      gb = got_q.size();
      pulse_start();
      wait_req(20);
      repeat (20) step();
      check("t2_req_held", 32'(sccb_req), 32'd1);
      check("t2_fields_held", 32'({sccb_reg, sccb_val}), 32'h12AB);
      hold_low = 1'b0;
      wait_done(200);
      compare_writes("t2", gb);
      $display("txn stall: %0d writes", got_q.size() - gb);

      // Empty table.
      clear_rom();
      rb = rise_q.size();
      pulse_start();
      step();
      step();
      check("t3_done_fast", 32'(done), 32'd1);
      check("t3_busy", 32'(busy), 32'd0);
      check("t3_no_req", 32'(rise_q.size() - rb), 32'd0);
      $display("txn empty table: done");

      // Reset while waiting on the third write, then replay.
      clear_rom();
      rom_mem[0] = 16'h1280;
      rom_mem[1] = 16'hFFF0;
      rom_mem[2] = 16'h1204;
      rom_mem[3] = 16'h1311;
      rom_mem[4] = 16'h1422;
      gb = got_q.size();
      pulse_start();
      n = 0;
      while (got_q.size() - gb < 3 && n < 1000) begin
         step();
         n++;
      end
      check("t4_reached_third", 32'(got_q.size() - gb), 32'd3);
      rst = 1'b1;
      #1;
      check("t4_req_drop_now", 32'(sccb_req), 32'd0);
      step();
      check("t4_outputs_zero",
            32'({rom_addr, sccb_req, sccb_reg, sccb_val, busy, done, error}), 32'd0);
      rst = 1'b0;
      gb = got_q.size();
      pulse_start();
      wait_done(1000);
      compare_writes("t4", gb);
      $display("txn reset mid-write: replayed %0d writes", got_q.size() - gb);

      // Start pulse during DELAY is ignored; start after done replays.
      load_basic();
      gb = got_q.size(); rb = rise_q.size(); db = done_q.size();
      pulse_start();
      n = 0;
      while (done_q.size() == db && n < 200) begin
         step();
         n++;
      end
      repeat (5) step();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done(500);
      compare_writes("t5", gb);
      gap = (rise_q.size() >= rb + 2 && done_q.size() >= db + 1) ? rise_q[rb + 1] - done_q[db] : -1;
      check("t5_delay_gap", 32'(gap), 32'(3 + DC + 2));
      gb = got_q.size();
      pulse_start();
      check("t5_done_cleared", 32'(done), 32'd0);
      wait_done(500);
      compare_writes("t5r", gb);
      $display("txn start while busy / restart: ok sequence");

      // Randomized tables, latencies and ready patterns.
      rand_ready = 1'b1;
      for (int it = 0; it < 6; it++) begin
         clear_rom();
         n = $urandom_range(1, 12);
         a = 0;
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) rom_mem[a++] = 16'hFFF0;
            rom_mem[a++] = rand_word();
         end
         lat = $urandom_range(1, 8);
         gb = got_q.size();
         pulse_start();
         wait_done(3000);
         compare_writes($sformatf("rnd%0d", it), gb);
         $display("txn random %0d: %0d entries, lat %0d, %0d writes", it, a, lat, got_q.size() - gb);
      end
      rand_ready = 1'b0;

      // Full table with no terminator ends at the last address.
      for (int i = 0; i < 256; i++) rom_mem[i] = rand_word();
      lat = 1;
      gb = got_q.size();
      pulse_start();
      wait_done(5000);
      compare_writes("wrap", gb);
      check("wrap_addr", 32'(rom_addr), 32'hFF);
      $display("txn full table: %0d writes", got_q.size() - gb);

`ifdef CFG_SCCB_TIMEOUT_EN
      // Watchdog trips when the master never finishes.
      clear_rom();
      rom_mem[0] = 16'h1280;
      lat = 0;
      pulse_start();
      wait_req(10);
      repeat (TC - 1) step();
      check("wd_not_yet", 32'(error), 32'd0);
      step();
      check("wd_error", 32'(error), 32'd1);
      check("wd_req", 32'(sccb_req), 32'd0);
      check("wd_done", 32'(done), 32'd0);
      check("wd_busy", 32'(busy), 32'd0);
      lat = 5;
      gb = got_q.size();
      pulse_start();
      check("wd_error_cleared", 32'(error), 32'd0);
      wait_done(500);
      compare_writes("wd_retry", gb);
      $display("txn watchdog: error then retry");
`else
      check("error_tied_low", 32'(error), 32'd0);
`endif

      check("fields_stable", 32'(stab_err), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
